pmp_seq_checker: RTL

//  Parametrised, multi-cycle PMP checker for the tinyriscv data/fetch path. Accepts one access

---
 rtl/pmp_pkg.sv | 38 +++
 rtl/pmp_entry_match.sv | 51 +++++
 rtl/pmp_seq_checker.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pmp_pkg.sv
// Shared PMP definitions: address-match modes, privilege levels, pmpcfg bit
// positions, access-type encoding and the checker FSM state type.
package pmp_pkg;

  typedef enum logic [1:0] {
    A_OFF   = 2'd0,
    A_TOR   = 2'd1,
    A_NA4   = 2'd2,
    A_NAPOT = 2'd3
  } pmp_amode_e;

  localparam logic [1:0] PRV_U = 2'b00;
  localparam logic [1:0] PRV_S = 2'b01;
  localparam logic [1:0] PRV_M = 2'b11;

  localparam int CFG_R    = 0;
  localparam int CFG_W    = 1;
  localparam int CFG_X    = 2;
  localparam int CFG_A_LO = 3;
  localparam int CFG_A_HI = 4;
  localparam int CFG_L    = 7;

  localparam logic [2:0] ACC_R = 3'b001;
  localparam logic [2:0] ACC_W = 3'b010;
  localparam logic [2:0] ACC_X = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } pmp_state_e;

  // Ones over the trailing-ones run plus the next bit: the don't-care word bits of a NAPOT region.
  function automatic logic [31:0] napot_mask(input logic [31:0] a);
    return a ^ (a + 32'd1);
  endfunction

endpackage

// File: rtl/pmp_entry_match.sv
// Combinational match of one PMP entry against the first and last word of an
// access; reports any overlap and the resulting permission for that entry.
module pmp_entry_match
  import pmp_pkg::*;
(
  input  logic [7:0]  cfg,
  input  logic [31:0] addr,
  input  logic [31:0] prev_addr,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  input  logic [2:0]  req_type,
  input  logic [1:0]  req_prv,
  output logic        match,
  output logic        allow
);

  logic [31:0] mask;
  logic        lo_in;
  logic        hi_in;
  logic        perm;
  logic        unused_cfg;

  always_comb begin
    mask  = napot_mask(addr);
    lo_in = 1'b0;
    hi_in = 1'b0;
    unique case (pmp_amode_e'(cfg[CFG_A_HI:CFG_A_LO]))
      A_TOR: begin
        lo_in = (lo_word >= prev_addr) && (lo_word < addr);
        hi_in = (hi_word >= prev_addr) && (hi_word < addr);
      end
      A_NA4: begin
        lo_in = (lo_word == addr);
        hi_in = (hi_word == addr);
      end
      A_NAPOT: begin
        lo_in = ((lo_word ^ addr) & ~mask) == 32'd0;
        hi_in = ((hi_word ^ addr) & ~mask) == 32'd0;
      end
      default: ;
    endcase
  end

  assign perm  = |(req_type & cfg[CFG_X:CFG_R]);
  // A straddling access (only one end inside) still claims priority but is never allowed.
  assign match = lo_in | hi_in;
  assign allow = lo_in & hi_in & (((req_prv == PRV_M) & ~cfg[CFG_L]) | perm);

  assign unused_cfg = ^cfg[6:5];

endmodule

// File: rtl/pmp_seq_checker.sv
// Multi-cycle PMP checker: scans ENTRIES_PER_CYCLE entries per cycle in priority
// order. Optional sticky fault capture is enabled by PMP_FAULT_CAPTURE_EN.
//
// state   | meaning
// ST_IDLE | ready for a request, request latched on accept
// ST_SCAN | evaluating chunk chunk_q; exits on first hit, last chunk or misalignment
// ST_RESP | result held on rsp_* until rsp_ready_i
module pmp_seq_checker
  import pmp_pkg::*;
#(
  parameter int PMP_CNT           = 16,
  parameter int ENTRIES_PER_CYCLE = 4,
  parameter int PLEN              = 34,
  localparam int IDX_W = (PMP_CNT > 1) ? $clog2(PMP_CNT) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [PLEN-1:0]          req_addr_i,
  input  logic [1:0]               req_size_i,
  input  logic [2:0]               req_type_i,
  input  logic [1:0]               req_prv_i,
  input  logic [PMP_CNT-1:0][7:0]  pmpcfg_i,
  input  logic [PMP_CNT-1:0][31:0] pmpaddr_i,
  input  logic                     cfg_update_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic                     rsp_allow_o,
  output logic                     rsp_hit_o,
  output logic [IDX_W-1:0]         rsp_entry_o,
  output logic                     fault_valid_o,
  output logic [PLEN-1:0]          fault_addr_o,
  output logic [2:0]               fault_type_o,
  input  logic                     fault_clr_i
);

  localparam int EPC     = ENTRIES_PER_CYCLE;
  localparam int N_CHUNK = PMP_CNT / EPC;
  localparam int CW      = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;

  pmp_state_e       state_q, state_d;
  logic [CW-1:0]    chunk_q, chunk_d;
  logic [PLEN-1:0]  addr_q;
  logic [1:0]       size_q;
  logic [2:0]       type_q;
  logic [1:0]       prv_q;
  logic             rsp_allow_q, rsp_hit_q;
  logic [IDX_W-1:0] rsp_entry_q;

  logic             rsp_load;
  logic             allow_d, hit_d;
  logic [IDX_W-1:0] entry_d;

  logic [PLEN-1:0]  size_bytes;
  logic [PLEN-1:0]  end_addr;
  logic             misaligned;
  logic [31:0]      lo_word, hi_word;

  logic [EPC-1:0]   ent_match, ent_allow;
  logic             chunk_hit, chunk_allow;
  logic [IDX_W-1:0] chunk_idx;

  assign size_bytes = PLEN'(1) << size_q;
  assign end_addr   = addr_q + size_bytes - PLEN'(1);
  assign misaligned = (addr_q & (size_bytes - PLEN'(1))) != '0;
  assign lo_word    = 32'(addr_q[PLEN-1:2]);
  assign hi_word    = 32'(end_addr[PLEN-1:2]);

  for (genvar j = 0; j < EPC; j++) begin : g_ent
    logic [IDX_W-1:0] idx;
    logic [31:0]      prev;
    assign idx  = IDX_W'(int'(chunk_q) * EPC + j);
    assign prev = (idx == '0) ? 32'd0 : pmpaddr_i[idx - 1'b1];
    pmp_entry_match u_match (
      .cfg       (pmpcfg_i[idx]),
      .addr      (pmpaddr_i[idx]),
      .prev_addr (prev),
      .lo_word   (lo_word),
      .hi_word   (hi_word),
      .req_type  (type_q),
      .req_prv   (prv_q),
      .match     (ent_match[j]),
      .allow     (ent_allow[j])
    );
  end

  // Descending walk so the lowest matching index in the chunk is the one kept.
  always_comb begin
    chunk_hit   = 1'b0;
    chunk_allow = 1'b0;
    chunk_idx   = '0;
    for (int j = EPC - 1; j >= 0; j--) begin
      if (ent_match[j]) begin
        chunk_hit   = 1'b1;
        chunk_allow = ent_allow[j];
        chunk_idx   = IDX_W'(int'(chunk_q) * EPC + j);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    chunk_d  = chunk_q;
    rsp_load = 1'b0;
    allow_d  = 1'b0;
    hit_d    = 1'b0;
    entry_d  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          state_d = ST_SCAN;
          chunk_d = '0;
        end
      end
      ST_SCAN: begin
        if (cfg_update_i) begin
          chunk_d = '0;
        end else if (misaligned) begin
          state_d  = ST_RESP;
          rsp_load = 1'b1;
        end else if (chunk_hit) begin
          state_d  = ST_RESP;
          rsp_load = 1'b1;
          allow_d  = chunk_allow;
          hit_d    = 1'b1;
          entry_d  = chunk_idx;
        end else if (chunk_q == CW'(N_CHUNK - 1)) begin
          state_d  = ST_RESP;
          rsp_load = 1'b1;
          allow_d  = (prv_q == PRV_M);
        end else begin
          chunk_d = chunk_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      chunk_q     <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      type_q      <= '0;
      prv_q       <= '0;
      rsp_allow_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_entry_q <= '0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      if (state_q == ST_IDLE && req_valid_i) begin
        addr_q <= req_addr_i;
        size_q <= req_size_i;
        type_q <= req_type_i;
        prv_q  <= req_prv_i;
      end
      if (rsp_load) begin
        rsp_allow_q <= allow_d;
        rsp_hit_q   <= hit_d;
        rsp_entry_q <= entry_d;
      end
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_allow_o = rsp_allow_q;
  assign rsp_hit_o   = rsp_hit_q;
  assign rsp_entry_o = rsp_entry_q;

`ifdef PMP_FAULT_CAPTURE_EN
  logic            fault_valid_q;
  logic [PLEN-1:0] fault_addr_q;
  logic [2:0]      fault_type_q;

  // First denied response is kept until cleared; a clear beats a same-cycle capture.
  always_ff @(posedge clk) begin
    if (!rst || fault_clr_i) begin
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
      fault_type_q  <= '0;
    end else if (rsp_load && !allow_d && !fault_valid_q) begin
      fault_valid_q <= 1'b1;
      fault_addr_q  <= addr_q;
      fault_type_q  <= type_q;
    end
  end

  assign fault_valid_o = fault_valid_q;
  assign fault_addr_o  = fault_addr_q;
  assign fault_type_o  = fault_type_q;
`else
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr_i;
  assign fault_valid_o    = 1'b0;
  assign fault_addr_o     = '0;
  assign fault_type_o     = '0;
`endif

endmodule
